// File: rtl/usb3_pipe_device_ltssm_responder.sv
// Device-side USB3 PIPE LTSSM responder: answers host TS1/TS2, walks Polling to U0.
// Define USB3_PIPE_RESP_STATS_EN to add saturating rx-set and abort counters.
module usb3_pipe_device_ltssm_responder #(
   parameter int DATA_BUS_WIDTH = 32,
   parameter int RX_TS_THRESH   = 8,
   parameter int TX_TS2_MIN     = 16,
   parameter int IDLE_WORDS     = 8,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_BUS_WIDTH-1:0] rx_data,
   input  logic [3:0]                rx_datak,
   input  logic                      rx_valid,
   input  logic                      rx_elec_idle,
   input  logic [7:0]                link_func,
   output logic [DATA_BUS_WIDTH-1:0] tx_data,
   output logic [3:0]                tx_datak,
   output logic                      tx_elec_idle,
   output logic [2:0]                ltssm_state,
   output logic                      link_up,
   output logic                      timeout_err
`ifdef USB3_PIPE_RESP_STATS_EN
   ,
   output logic [15:0]               ts1_rx_cnt,
   output logic [15:0]               ts2_rx_cnt,
   output logic [7:0]                abort_cnt
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACTIVE = 3'd1,
      ST_CONFIG = 3'd2,
      ST_PIDLE  = 3'd3,
      ST_U0     = 3'd4
   } state_t;

   localparam logic [31:0] COM_WORD = 32'hBCBCBCBC;
   localparam logic [7:0]  ID_TS1   = 8'h4A;
   localparam logic [7:0]  ID_TS2   = 8'h45;
   localparam int          TO_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  RX_THR   = 8'(RX_TS_THRESH);
   localparam logic [7:0]  TS2_MIN  = 8'(TX_TS2_MIN);
   localparam logic [7:0]  IDLE_MIN = 8'(IDLE_WORDS);

   state_t          state_reg, state_next;
   logic [1:0]      wc_reg;
   logic            adv_reg;
   logic [TO_W-1:0] to_cnt_reg;
   logic            ts2_seen_reg;
   logic [7:0]      ts2_sent_reg, idle_sent_reg;

   logic            in_set_reg;
   logic [1:0]      pw_reg;
   logic [7:0]      set_id_reg, last_id_reg, rx_cnt_reg, rx_idle_cnt_reg;

   logic            rx_is_com, rx_is_idle, w1_ok, wn_ok, word_ok, set_done;
   logic            active, to_abort, abort, cond;
   logic [7:0]      tx_id;

   always_comb begin
      rx_is_com  = (rx_data == COM_WORD) && (rx_datak == 4'hF);
      rx_is_idle = (rx_data == '0) && (rx_datak == 4'h0);
      // Byte 5 (link functionality) is deliberately ignored on receive.
      w1_ok      = (rx_datak == 4'h0) && (rx_data[31:24] == rx_data[23:16]) &&
                   (rx_data[7:0] == 8'h00) &&
                   ((rx_data[31:24] == ID_TS1) || (rx_data[31:24] == ID_TS2));
      wn_ok      = (rx_datak == 4'h0) && (rx_data == {4{set_id_reg}});
      word_ok    = (pw_reg == 2'd1) ? w1_ok : wn_ok;
      set_done   = rx_valid && in_set_reg && (pw_reg == 2'd3) && wn_ok;
   end

   always_comb begin
      active   = (state_reg == ST_ACTIVE) || (state_reg == ST_CONFIG) || (state_reg == ST_PIDLE);
      to_abort = active && (to_cnt_reg == TO_LAST);
      abort    = to_abort || ((state_reg != ST_IDLE) && rx_elec_idle);
      cond     = 1'b0;
      case (state_reg)
         ST_ACTIVE: cond = (rx_cnt_reg >= RX_THR);
         ST_CONFIG: cond = (rx_cnt_reg >= RX_THR) && (last_id_reg == ID_TS2) &&
                           (ts2_sent_reg >= TS2_MIN);
         ST_PIDLE:  cond = (rx_idle_cnt_reg >= IDLE_MIN) && (idle_sent_reg >= IDLE_MIN);
         default:   cond = 1'b0;
      endcase
      // Normal advances wait for the last word of the current tx set.
      state_next = state_reg;
      if (abort) begin
         state_next = ST_IDLE;
      end else if (state_reg == ST_IDLE) begin
         if (rx_valid && rx_is_com && !rx_elec_idle) state_next = ST_ACTIVE;
      end else if ((wc_reg == 2'd3) && (adv_reg || cond)) begin
         case (state_reg)
            ST_ACTIVE: state_next = ST_CONFIG;
            ST_CONFIG: state_next = ST_PIDLE;
            ST_PIDLE:  state_next = ST_U0;
            default:   state_next = state_reg;
         endcase
      end
      tx_id = (state_reg == ST_CONFIG) ? ID_TS2 : ID_TS1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_set_reg      <= 1'b0;
         pw_reg          <= 2'd0;
         set_id_reg      <= 8'h00;
         last_id_reg     <= 8'h00;
         rx_cnt_reg      <= 8'h00;
         rx_idle_cnt_reg <= 8'h00;
      end else if (abort) begin
         in_set_reg      <= 1'b0;
         pw_reg          <= 2'd0;
         last_id_reg     <= 8'h00;
         rx_cnt_reg      <= 8'h00;
         rx_idle_cnt_reg <= 8'h00;
      end else if (rx_valid) begin
         if (!rx_is_idle)                  rx_idle_cnt_reg <= 8'h00;
         else if (rx_idle_cnt_reg != 8'hFF) rx_idle_cnt_reg <= rx_idle_cnt_reg + 8'd1;
         if (!in_set_reg) begin
            in_set_reg <= rx_is_com;
            pw_reg     <= 2'd1;
         end else if (!word_ok) begin
            // A mismatching COM word immediately opens a fresh set.
            rx_cnt_reg <= 8'h00;
            in_set_reg <= rx_is_com;
            pw_reg     <= 2'd1;
         end else if (pw_reg == 2'd3) begin
            in_set_reg  <= 1'b0;
            last_id_reg <= set_id_reg;
            if ((set_id_reg == last_id_reg) && (rx_cnt_reg != 8'h00)) begin
               if (rx_cnt_reg != 8'hFF) rx_cnt_reg <= rx_cnt_reg + 8'd1;
            end else begin
               rx_cnt_reg <= 8'd1;
            end
         end else begin
            if (pw_reg == 2'd1) set_id_reg <= rx_data[31:24];
            pw_reg <= pw_reg + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         wc_reg        <= 2'd0;
         adv_reg       <= 1'b0;
         to_cnt_reg    <= '0;
         ts2_seen_reg  <= 1'b0;
         ts2_sent_reg  <= 8'h00;
         idle_sent_reg <= 8'h00;
         tx_data       <= '0;
         tx_datak      <= 4'h0;
         tx_elec_idle  <= 1'b1;
         ltssm_state   <= 3'd0;
         link_up       <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ltssm_state <= state_next;
         link_up     <= (state_next == ST_U0);
         timeout_err <= to_abort;
         if (state_next != state_reg) begin
            wc_reg        <= 2'd0;
            adv_reg       <= 1'b0;
            to_cnt_reg    <= '0;
            ts2_sent_reg  <= 8'h00;
            idle_sent_reg <= 8'h00;
         end else begin
            wc_reg <= (state_reg == ST_IDLE) ? 2'd0 : wc_reg + 2'd1;
            if (cond)   adv_reg    <= 1'b1;
            if (active) to_cnt_reg <= to_cnt_reg + TO_W'(1);
            if ((state_reg == ST_CONFIG) && ts2_seen_reg && (wc_reg == 2'd3) &&
                (ts2_sent_reg != 8'hFF))
               ts2_sent_reg <= ts2_sent_reg + 8'd1;
            if ((state_reg == ST_PIDLE) && (idle_sent_reg != 8'hFF))
               idle_sent_reg <= idle_sent_reg + 8'd1;
         end
         if (state_next == ST_IDLE)               ts2_seen_reg <= 1'b0;
         else if (set_done && (set_id_reg == ID_TS2)) ts2_seen_reg <= 1'b1;
         tx_elec_idle <= (state_reg == ST_IDLE);
         tx_data      <= '0;
         tx_datak     <= 4'h0;
         if ((state_reg == ST_ACTIVE) || (state_reg == ST_CONFIG)) begin
            case (wc_reg)
               2'd0: begin
                  tx_data  <= COM_WORD;
                  tx_datak <= 4'hF;
               end
               2'd1:    tx_data <= {tx_id, tx_id, link_func, 8'h00};
               default: tx_data <= {4{tx_id}};
            endcase
         end
      end
   end

`ifdef USB3_PIPE_RESP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts1_rx_cnt <= 16'h0000;
         ts2_rx_cnt <= 16'h0000;
         abort_cnt  <= 8'h00;
      end else begin
         if (set_done && (set_id_reg == ID_TS1) && (ts1_rx_cnt != 16'hFFFF))
            ts1_rx_cnt <= ts1_rx_cnt + 16'd1;
         if (set_done && (set_id_reg == ID_TS2) && (ts2_rx_cnt != 16'hFFFF))
            ts2_rx_cnt <= ts2_rx_cnt + 16'd1;
         if (abort && (abort_cnt != 8'hFF))
            abort_cnt <= abort_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_usb3_pipe_device_ltssm_responder.sv
// Scoreboard bench for usb3_pipe_device_ltssm_responder: link-up, bad set, timeout,
// electrical-idle abort and asynchronous reset scenarios.
module tb_usb3_pipe_device_ltssm_responder;

   localparam logic [7:0]  TS1     = 8'h4A;
   localparam logic [7:0]  TS2     = 8'h45;
   localparam logic [31:0] COM     = 32'hBCBCBCBC;
   localparam int          TIMEOUT = 65536;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rx_data = 32'h0;
   logic [3:0]  rx_datak = 4'h0;
   logic        rx_valid = 1'b0;
   logic        rx_elec_idle = 1'b0;
   logic [7:0]  link_func = 8'h5A;
   logic [31:0] tx_data;
   logic [3:0]  tx_datak;
   logic        tx_elec_idle;
   logic [2:0]  ltssm_state;
   logic        link_up;
   logic        timeout_err;
`ifdef USB3_PIPE_RESP_STATS_EN
   logic [15:0] ts1_rx_cnt, ts2_rx_cnt;
   logic [7:0]  abort_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0] state_log[$];
   logic [7:0] lf_log[$];
   logic [2:0] exp_q[$];
   logic [2:0] mon_prev = 3'd0;

   always #5 clk = ~clk;

   usb3_pipe_device_ltssm_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_datak     (rx_datak),
      .rx_valid     (rx_valid),
      .rx_elec_idle (rx_elec_idle),
      .link_func    (link_func),
      .tx_data      (tx_data),
      .tx_datak     (tx_datak),
      .tx_elec_idle (tx_elec_idle),
      .ltssm_state  (ltssm_state),
      .link_up      (link_up),
      .timeout_err  (timeout_err)
`ifdef USB3_PIPE_RESP_STATS_EN
      ,
      .ts1_rx_cnt   (ts1_rx_cnt),
      .ts2_rx_cnt   (ts2_rx_cnt),
      .abort_cnt    (abort_cnt)
`endif
   );

   // Log state changes and the link-function byte of every transmitted TS1 W1.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ltssm_state != mon_prev) state_log.push_back(ltssm_state);
         if (tx_datak == 4'h0 && tx_data[31:16] == 16'h4A4A && tx_data[7:0] == 8'h00)
            lf_log.push_back(tx_data[15:8]);
      end
      mon_prev <= ltssm_state;
   end

   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v);
      rx_data  = d;
      rx_datak = k;
      rx_valid = v;
      @(negedge clk);
   endtask

   task automatic drive_ts(input logic [7:0] id, input int idx, input logic bad);
      logic [31:0] w;
      case (idx)
         0:       w = COM;
         1:       w = {id, id, 8'hC3, 8'h00};
         default: w = {4{id}};
      endcase
      if (bad && idx == 2) w[0] = ~w[0];
      drive(w, (idx == 0) ? 4'hF : 4'h0, 1'b1);
   endtask

   task automatic send_os(input logic [7:0] id, input logic bad);
      for (int i = 0; i < 4; i++) drive_ts(id, i, bad);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_valid = 1'b0;
      rx_data = 32'h0;
      rx_datak = 4'h0;
      rx_elec_idle = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ltssm_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", ltssm_state); end
      checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
      checks++; if (tx_datak !== 4'h0) begin errors++; $display("FAIL reset_tx_datak: got %h want 0", tx_datak); end
      checks++; if (tx_elec_idle !== 1'b1) begin errors++; $display("FAIL reset_tx_elec_idle: got %b want 1", tx_elec_idle); end
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b want 0", link_up); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
`ifdef USB3_PIPE_RESP_STATS_EN
      checks++; if (ts1_rx_cnt !== 16'd0 || ts2_rx_cnt !== 16'd0 || abort_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", ts1_rx_cnt, ts2_rx_cnt, abort_cnt);
      end
`endif
      $display("test_reset done");
   endtask

   task automatic test_link_up();
      int base_s, base_l, idx, n, nlf;
      logic [2:0] e, got;
      do_reset();
      base_s = state_log.size();
      base_l = lf_log.size();
      exp_q.push_back(3'd1);
      repeat (8) send_os(TS1, 1'b0);
      exp_q.push_back(3'd2);
      repeat (16) send_os(TS2, 1'b0);
      exp_q.push_back(3'd3);
      exp_q.push_back(3'd4);
      n = 0;
      while (link_up !== 1'b1 && n < 2000) begin
         drive(32'h0, 4'h0, 1'b1);
         n++;
      end
      repeat (2) drive(32'h0, 4'h0, 1'b1);
      checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL link_up: got %b want 1", link_up); end
      idx = base_s;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         got = (idx < state_log.size()) ? state_log[idx] : 3'd7;
         checks++; if (got !== e) begin errors++; $display("FAIL state_seq[%0d]: got %0d want %0d", idx - base_s, got, e); end
         idx++;
      end
      checks++; if (state_log.size() - base_s != 4) begin
         errors++; $display("FAIL state_seq_len: got %0d want 4", state_log.size() - base_s);
      end
      nlf = lf_log.size() - base_l;
      checks++; if (nlf < 4) begin errors++; $display("FAIL tx_ts1_count: got %0d want >=4", nlf); end
      for (int i = base_l; i < lf_log.size(); i++) begin
         checks++; if (lf_log[i] !== 8'h5A) begin errors++; $display("FAIL tx_ts1_byte5: got %h want 5a", lf_log[i]); end
      end
`ifdef USB3_PIPE_RESP_STATS_EN
      checks++; if (ts1_rx_cnt !== 16'd8) begin errors++; $display("FAIL stats_ts1: got %0d want 8", ts1_rx_cnt); end
      checks++; if (ts2_rx_cnt !== 16'd16) begin errors++; $display("FAIL stats_ts2: got %0d want 16", ts2_rx_cnt); end
      checks++; if (abort_cnt !== 8'd0) begin errors++; $display("FAIL stats_abort: got %0d want 0", abort_cnt); end
`endif
      $display("test_link_up done after %0d idle words", n);
   endtask

   task automatic test_bad_set();
      int n;
      do_reset();
      repeat (7) send_os(TS1, 1'b0);
      send_os(TS1, 1'b1);
      repeat (7) send_os(TS1, 1'b0);
      repeat (8) drive(32'h0, 4'h0, 1'b0);
      checks++; if (ltssm_state !== 3'd1) begin errors++; $display("FAIL bad_set_hold: got %0d want 1", ltssm_state); end
      send_os(TS1, 1'b0);
      n = 0;
      while (ltssm_state !== 3'd2 && n < 16) begin
         drive(32'h0, 4'h0, 1'b0);
         n++;
      end
      checks++; if (ltssm_state !== 3'd2) begin errors++; $display("FAIL bad_set_advance: got %0d want 2", ltssm_state); end
      $display("test_bad_set done");
   endtask

   task automatic test_timeout();
      int cyc;
      do_reset();
      drive_ts(TS1, 0, 1'b0);
      checks++; if (ltssm_state !== 3'd1) begin errors++; $display("FAIL timeout_enter: got %0d want 1", ltssm_state); end
      cyc = 0;
      while (timeout_err !== 1'b1 && cyc < 70000) begin
         if (cyc < 3) drive_ts(TS1, cyc + 1, 1'b0);
         else         drive(32'h0, 4'h0, 1'b0);
         cyc++;
      end
      checks++; if (cyc != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TIMEOUT); end
      checks++; if (ltssm_state !== 3'd0) begin errors++; $display("FAIL timeout_state: got %0d want 0", ltssm_state); end
      drive(32'h0, 4'h0, 1'b0);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_err); end
      checks++; if (tx_elec_idle !== 1'b1) begin errors++; $display("FAIL timeout_tx_elec_idle: got %b want 1", tx_elec_idle); end
      $display("test_timeout done after %0d cycles", cyc);
   endtask

   task automatic test_elec_idle();
      int n;
      do_reset();
      repeat (8) send_os(TS1, 1'b0);
      repeat (2) send_os(TS2, 1'b0);
      n = 0;
      while (ltssm_state !== 3'd2 && n < 16) begin
         drive(32'h0, 4'h0, 1'b0);
         n++;
      end
      checks++; if (ltssm_state !== 3'd2) begin errors++; $display("FAIL elec_idle_pre: got %0d want 2", ltssm_state); end
      rx_elec_idle = 1'b1;
      drive(32'h0, 4'h0, 1'b0);
      checks++; if (ltssm_state !== 3'd0) begin errors++; $display("FAIL elec_idle_state: got %0d want 0", ltssm_state); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL elec_idle_no_err: got %b want 0", timeout_err); end
      rx_elec_idle = 1'b0;
      drive(32'h0, 4'h0, 1'b0);
      checks++; if (timeout_err !== 1'b0 || tx_elec_idle !== 1'b1) begin
         errors++; $display("FAIL elec_idle_after: got err=%b eidle=%b want 0/1", timeout_err, tx_elec_idle);
      end
      $display("test_elec_idle done");
   endtask

   task automatic test_async_reset();
      int n;
      logic found;
      do_reset();
      repeat (8) send_os(TS1, 1'b0);
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         drive_ts(TS2, n % 4, 1'b0);
         if (tx_datak == 4'h0 && tx_data[31:16] == 16'h4545 && tx_data[7:0] == 8'h00) found = 1'b1;
         n++;
      end
      drive_ts(TS2, n % 4, 1'b0);
      checks++; if (tx_data !== 32'h45454545) begin errors++; $display("FAIL arst_pre_w2: got %h want 45454545", tx_data); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ltssm_state !== 3'd0 || link_up !== 1'b0 || timeout_err !== 1'b0) begin
         errors++; $display("FAIL arst_state: got st=%0d lu=%b te=%b want 0/0/0", ltssm_state, link_up, timeout_err);
      end
      checks++; if (tx_data !== 32'h0 || tx_datak !== 4'h0 || tx_elec_idle !== 1'b1) begin
         errors++; $display("FAIL arst_tx: got %h/%h/%b want 0/0/1", tx_data, tx_datak, tx_elec_idle);
      end
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) drive(32'h0, 4'h0, 1'b0);
      checks++; if (tx_elec_idle !== 1'b1) begin errors++; $display("FAIL arst_idle_hold: got %b want 1", tx_elec_idle); end
      drive_ts(TS1, 0, 1'b0);
      drive_ts(TS1, 1, 1'b0);
      checks++; if (tx_elec_idle !== 1'b0 || tx_data !== COM || tx_datak !== 4'hF) begin
         errors++; $display("FAIL arst_first_w0: got %b/%h/%h want 0/bcbcbcbc/f", tx_elec_idle, tx_data, tx_datak);
      end
      drive_ts(TS1, 2, 1'b0);
      checks++; if (tx_data !== 32'h4A4A5A00) begin errors++; $display("FAIL arst_first_w1: got %h want 4a4a5a00", tx_data); end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_link_up();
      test_bad_set();
      test_elec_idle();
      test_async_reset();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
